// File: rtl/shared_alu_pkg.sv
// Shared types and default sizes for the shared_alu_arbiter slice.
// The early-terminating multiply is enabled by defining SHARED_ALU_EARLY_TERM_EN.
package shared_alu_pkg;

  localparam int NREQ_DEF = 4;
  localparam int N_DEF    = 8;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MUL  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/shared_alu_arbiter_addsub.sv
// Plain W-bit adder/subtractor; subtraction is a + ~b + 1.
module adder_subtractor #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum
);

  assign sum = a + (sub ? ~b : b) + W'(sub);

endmodule

// File: rtl/shared_alu_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr+1 with wrap and
// returns a one-hot grant plus the encoded index of the winner.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);

  logic found;
  int   cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = (int'(ptr) + i) % NREQ;
      if (!found && req_valid[cand[IW-1:0]]) begin
        found                = 1'b1;
        grant[cand[IW-1:0]]  = 1'b1;
        idx                  = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/shared_alu_arbiter.sv
// Round-robin front end sharing one 2N-bit add/sub datapath (ADD, SUB, shift-add MUL).
// Define SHARED_ALU_EARLY_TERM_EN to end MUL as soon as the remaining multiplier is zero.
module shared_alu_arbiter
  import shared_alu_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  parameter  int N    = N_DEF,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  // Request and response channels: a transfer happens on any edge where
  // valid & ready are both high; valid may not depend on ready.
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0][1:0]     req_op,
  input  logic [NREQ-1:0][N-1:0]   req_a,
  input  logic [NREQ-1:0][N-1:0]   req_b,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [IW-1:0]            resp_id,
  output logic [2*N-1:0]           resp_data,
  output logic                     busy,
  output state_e                   state_dbg
);

  localparam int CW = $clog2(N) + 1;

  state_e            state_q, state_d;
  logic [IW-1:0]     ptr_q, id_q, gidx;
  logic [NREQ-1:0]   grant;
  logic              hs, mul_last;
  op_e               win_op;
  logic [N-1:0]      win_a, win_b;
  logic [2*N-1:0]    res_q, mcand_q;
  logic [N-1:0]      mplier_q;
  logic [CW-1:0]     cnt_q;
  logic [2*N-1:0]    add_a, add_b, add_sum;
  logic              add_sub;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .idx       (gidx)
  );

  assign win_op = op_e'(req_op[gidx]);
  assign win_a  = req_a[gidx];
  assign win_b  = req_b[gidx];
  assign hs     = |req_ready;

  // The one adder serves the accept-time ADD/SUB and every MUL accumulate step.
  always_comb begin
    add_a   = res_q;
    add_b   = mplier_q[0] ? mcand_q : '0;
    add_sub = 1'b0;
    if (state_q == IDLE) begin
      add_a   = {{N{1'b0}}, win_a};
      add_b   = {{N{1'b0}}, win_b};
      add_sub = (win_op == OP_SUB);
    end
  end

  adder_subtractor #(.W(2*N)) u_addsub (
    .a   (add_a),
    .b   (add_b),
    .sub (add_sub),
    .sum (add_sum)
  );

`ifdef SHARED_ALU_EARLY_TERM_EN
  assign mul_last = (mplier_q[N-1:1] == '0);
`else
  assign mul_last = (cnt_q == CW'(N - 1));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs) state_d = (win_op == OP_MUL) ? MUL : DONE;
      MUL:     if (mul_last) state_d = DONE;
      DONE:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset gates req_ready directly so grants vanish the moment reset rises.
  always_comb begin
    req_ready  = (state_q == IDLE && !reset) ? grant : '0;
    resp_valid = (state_q == DONE);
    busy       = (state_q != IDLE);
    resp_data  = res_q;
    resp_id    = id_q;
    state_dbg  = state_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q    <= IW'(NREQ - 1);
      id_q     <= '0;
      res_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hs) begin
            ptr_q <= gidx;
            id_q  <= gidx;
            case (win_op)
              OP_ADD: res_q <= add_sum;
              // Bit N of the wide difference is set exactly when a < b.
              OP_SUB: res_q <= {{(N-1){1'b0}}, add_sum[N], add_sum[N-1:0]};
              OP_MUL: begin
                res_q    <= '0;
                mcand_q  <= {{N{1'b0}}, win_a};
                mplier_q <= win_b;
                cnt_q    <= '0;
              end
              default: res_q <= '0;
            endcase
          end
        end
        MUL: begin
          res_q    <= add_sum;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_alu_arbiter.sv
// Directed bench for shared_alu_arbiter: reset, ADD/SUB/reserved/MUL results and
// latency, round-robin order with backpressure, and reset abort of a MUL.
module tb_shared_alu_arbiter;
  import shared_alu_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       req_valid;
  logic [3:0]       req_ready;
  logic [3:0][1:0]  req_op;
  logic [3:0][7:0]  req_a, req_b;
  logic             resp_valid, resp_ready;
  logic [1:0]       resp_id;
  logic [15:0]      resp_data;
  logic             busy;
  state_e           state_dbg;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] fair_tab [4];
  logic [15:0] exp_d;
  int          lat, exp_lat;

  shared_alu_arbiter #(.NREQ(4), .N(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drivers
  task automatic set_req(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    req_op[i] = op;
    req_a[i]  = a;
    req_b[i]  = b;
  endtask

  task automatic resp_handshake();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("back_to_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = '0;
    req_op     = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    fair_tab[0] = 16'h00FA;  // 200+50
    fair_tab[1] = 16'h0105;  // 210+51
    fair_tab[2] = 16'h0110;  // 220+52
    fair_tab[3] = 16'h011B;  // 230+53
`ifdef SHARED_ALU_EARLY_TERM_EN
    exp_lat = 2;
`else
    exp_lat = 9;
`endif

    repeat (2) @(negedge clk);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_resp_data", {16'd0, resp_data}, 32'd0);
    chk("rst_resp_id", {30'd0, resp_id}, 32'd0);
    req_valid = 4'hF;
    #1 chk("rst_hold_ready", {28'd0, req_ready}, 32'd0);
    reset = 1'b0;
    #1 chk("post_rst_grant", {28'd0, req_ready}, 32'h1);

    // ADD 200+100 from req0
    set_req(0, 2'b00, 8'd200, 8'd100);
    req_valid = 4'b0001;
    #1 chk("add_grant", {28'd0, req_ready}, 32'h1);
    @(negedge clk);
    req_valid = '0;
    chk("add_valid", {31'd0, resp_valid}, 32'd1);
    chk("add_data", {16'd0, resp_data}, 32'h012C);
    chk("add_id", {30'd0, resp_id}, 32'd0);
    chk("add_ready_low", {28'd0, req_ready}, 32'd0);
    chk("add_busy", {31'd0, busy}, 32'd1);
    resp_handshake();

    // SUB 5-7 from req1
    set_req(1, 2'b01, 8'd5, 8'd7);
    req_valid = 4'b0010;
    #1 chk("sub_grant", {28'd0, req_ready}, 32'h2);
    @(negedge clk);
    req_valid = '0;
    chk("sub_data", {16'd0, resp_data}, 32'h01FE);
    chk("sub_id", {30'd0, resp_id}, 32'd1);
    resp_handshake();

    // Reserved op from req2
    set_req(2, 2'b11, 8'd5, 8'd3);
    req_valid = 4'b0100;
    #1 chk("rsvd_grant", {28'd0, req_ready}, 32'h4);
    @(negedge clk);
    req_valid = '0;
    chk("rsvd_valid", {31'd0, resp_valid}, 32'd1);
    chk("rsvd_data", {16'd0, resp_data}, 32'h0000);
    chk("rsvd_id", {30'd0, resp_id}, 32'd2);
    resp_handshake();

    // MUL 255*255 from req3: 8 iterations in either build
    set_req(3, 2'b10, 8'd255, 8'd255);
    req_valid = 4'b1000;
    #1 chk("mul_grant", {28'd0, req_ready}, 32'h8);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      req_valid = '0;
      chk("mul_wait_valid", {31'd0, resp_valid}, 32'd0);
      chk("mul_wait_ready", {28'd0, req_ready}, 32'd0);
    end
    @(negedge clk);
    chk("mul_valid_t9", {31'd0, resp_valid}, 32'd1);
    chk("mul_data", {16'd0, resp_data}, 32'hFE01);
    chk("mul_id", {30'd0, resp_id}, 32'd3);
    resp_handshake();

    // MUL 13*1 from req0: latency depends on early termination
    set_req(0, 2'b10, 8'd13, 8'd1);
    req_valid = 4'b0001;
    #1 chk("mul1_grant", {28'd0, req_ready}, 32'h1);
    lat = 0;
    do begin
      @(negedge clk);
      req_valid = '0;
      lat++;
    end while (!resp_valid && lat < 20);
    chk("mul1_latency", lat, exp_lat);
    chk("mul1_data", {16'd0, resp_data}, 32'h000D);
    chk("mul1_id", {30'd0, resp_id}, 32'd0);
    resp_handshake();

    // Fairness with backpressure, from a fresh reset
    reset = 1'b1;
    #1 chk("pulse_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 2'b00, 8'(200 + 10 * i), 8'(50 + i));
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1 chk("fair_grant", {28'd0, req_ready}, 32'(1 << (k % 4)));
      exp_q.push_back(fair_tab[k % 4]);
      resp_ready = (k != 0);
      @(negedge clk);
      exp_d = exp_q.pop_front();
      chk("fair_valid", {31'd0, resp_valid}, 32'd1);
      chk("fair_data", {16'd0, resp_data}, {16'd0, exp_d});
      chk("fair_id", {30'd0, resp_id}, 32'(k % 4));
      if (k == 0) begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_valid", {31'd0, resp_valid}, 32'd1);
          chk("bp_data", {16'd0, resp_data}, {16'd0, fair_tab[0]});
          chk("bp_id", {30'd0, resp_id}, 32'd0);
          chk("bp_ready_low", {28'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
      end
      @(negedge clk);
    end
    req_valid  = '0;
    resp_ready = 1'b0;

    // Abort: reset during MUL cycle 4 of req3
    set_req(3, 2'b10, 8'd13, 8'd11);
    req_valid = 4'b1000;
    #1 chk("abort_grant", {28'd0, req_ready}, 32'h8);
    repeat (4) @(negedge clk);
    chk("abort_in_mul", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("abort_req_ready", {28'd0, req_ready}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_resp_data", {16'd0, resp_data}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    set_req(0, 2'b00, 8'd1, 8'd2);
    req_valid = 4'b1001;
    #1 chk("abort_req0_wins", {28'd0, req_ready}, 32'h1);
    @(negedge clk);
    req_valid = '0;
    chk("abort_next_data", {16'd0, resp_data}, 32'h0003);
    chk("abort_next_id", {30'd0, resp_id}, 32'd0);
    resp_handshake();
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_resp", {31'd0, resp_valid}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
